// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the shared memory port.
// Handshake: a requester raises req with stable address/data and holds it until its
// rvalid pulse; gnt pulses for one cycle when its access is issued, and the memory
// side sees exactly one mem_en cycle per access with read data due MEM_LAT cycles later.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic          stall_mem;
  logic          busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and data access,
// issuing one fixed-latency access at a time and returning data to the owning stage.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2,
  parameter int DM_PRIO = 1
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [3:0] LAT      = 4'(MEM_LAT);
  localparam logic       DM_FIRST = (DM_PRIO != 0);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          own_dm_q, own_dm_d;
  logic          we_q, we_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          if_gnt_q, if_gnt_d;
  logic          dm_gnt_q, dm_gnt_d;
  logic          if_rv_q, if_rv_d;
  logic          dm_rv_q, dm_rv_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_elig, dm_elig, pick_if, pick_dm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      own_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_gnt_q   <= 1'b0;
      dm_gnt_q   <= 1'b0;
      if_rv_q    <= 1'b0;
      dm_rv_q    <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      own_dm_q   <= own_dm_d;
      we_q       <= we_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_gnt_q   <= if_gnt_d;
      dm_gnt_q   <= dm_gnt_d;
      if_rv_q    <= if_rv_d;
      dm_rv_q    <= dm_rv_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    // A requester being answered this cycle is masked so the other side gets its turn.
    if_elig    = bus.if_req & ~if_rv_q;
    dm_elig    = bus.dm_req & ~dm_rv_q;
    pick_dm    = dm_elig & (~if_elig | DM_FIRST);
    pick_if    = if_elig & ~pick_dm;
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_dm_d   = own_dm_q;
    we_d       = we_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_gnt_d   = 1'b0;
    dm_gnt_d   = 1'b0;
    if_rv_d    = 1'b0;
    dm_rv_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_dm | pick_if) begin
          state_d  = BUSY;
          cnt_d    = LAT;
          own_dm_d = pick_dm;
          we_d     = pick_dm & bus.dm_we;
          addr_d   = pick_dm ? bus.dm_addr : bus.if_addr;
          wdata_d  = pick_dm ? bus.dm_wdata : wdata_q;
          mem_en_d = 1'b1;
          mem_we_d = pick_dm & bus.dm_we;
          if_gnt_d = pick_if;
          dm_gnt_d = pick_dm;
        end
      end
      BUSY: begin
        // cnt hits zero in the cycle mem_rdata is valid; the answer goes out next cycle.
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          if (own_dm_q) begin
            dm_rv_d    = 1'b1;
            dm_rdata_d = we_q ? '0 : bus.mem_rdata;
          end else begin
            if_rv_d    = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.dm_gnt    = dm_gnt_q;
  assign bus.if_rvalid = if_rv_q;
  assign bus.dm_rvalid = dm_rv_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.stall_if  = bus.if_req & ~if_rv_q;
  assign bus.stall_mem = bus.dm_req & ~dm_rv_q;
  assign bus.busy      = (state_q == BUSY);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all checked
// every cycle against a transaction-level schedule model and a reference memory.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int PRI = 1;

  logic clk;
  logic rst;
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .DM_PRIO(PRI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;
  int auto_mode;

  // requester-side transaction state, index 0 = fetch, 1 = data
  bit          pend[2];
  bit          dropped[2];
  logic [31:0] t_addr[2];
  bit          t_we;
  logic [31:0] t_wdata;

  // scheduled access of the reference model
  bit          m_active;
  bit          m_own_dm;
  int          m_gnt_c;
  int          m_done_c;
  logic [31:0] m_addr;
  bit          m_we;
  logic [31:0] m_wdata;
  logic [31:0] e_if_rdata, e_dm_rdata, e_mem_addr, e_mem_wdata;
  bit x_if_gnt, x_dm_gnt, x_if_rv, x_dm_rv, x_mem_en, x_mem_we, x_busy, x_stall_if, x_stall_mem;

  logic [31:0] env_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int          env_issue_c;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic start_txn(input int p, input logic [31:0] a, input bit we, input logic [31:0] wd);
    pend[p]    = 1'b1;
    dropped[p] = 1'b0;
    t_addr[p]  = a;
    if (p == 1) begin
      t_we    = we;
      t_wdata = wd;
    end
  endtask

  function automatic bit inflight(input int p);
    return pend[p] && m_active && (m_own_dm == (p == 1)) && (cyc >= m_gnt_c);
  endfunction

  task automatic model_eval();
    bit e_if, e_dm;
    if (rst) begin
      m_active    = 1'b0;
      e_if_rdata  = '0;
      e_dm_rdata  = '0;
      e_mem_addr  = '0;
      e_mem_wdata = '0;
      env_issue_c = -100;
      dropped[0]  = 1'b0;
      dropped[1]  = 1'b0;
      {x_if_gnt, x_dm_gnt, x_if_rv, x_dm_rv, x_mem_en, x_mem_we, x_busy} = '0;
      x_stall_if  = bus.if_req;
      x_stall_mem = bus.dm_req;
      return;
    end
    if (m_active && cyc == m_gnt_c) begin
      e_mem_addr = m_addr;
      if (m_own_dm) e_mem_wdata = m_wdata;
    end
    x_mem_en = m_active && cyc == m_gnt_c;
    x_mem_we = x_mem_en && m_we;
    x_if_gnt = x_mem_en && !m_own_dm;
    x_dm_gnt = x_mem_en && m_own_dm;
    x_busy   = m_active && cyc >= m_gnt_c && cyc < m_done_c;
    x_if_rv  = m_active && cyc == m_done_c && !m_own_dm;
    x_dm_rv  = m_active && cyc == m_done_c && m_own_dm;
    if (x_mem_we) ref_mem[m_addr] = m_wdata;
    if (x_if_rv) e_if_rdata = ref_rd(m_addr);
    if (x_dm_rv) e_dm_rdata = m_we ? 32'h0 : ref_rd(m_addr);
    if (m_active && cyc == m_done_c) m_active = 1'b0;
    x_stall_if  = bus.if_req && !x_if_rv;
    x_stall_mem = bus.dm_req && !x_dm_rv;
    e_if = bus.if_req && !x_if_rv;
    e_dm = bus.dm_req && !x_dm_rv;
    if (!m_active && (e_if || e_dm)) begin
      m_own_dm = e_dm && (!e_if || PRI != 0);
      m_active = 1'b1;
      m_gnt_c  = cyc + 1;
      m_done_c = cyc + 2 + LAT;
      m_addr   = m_own_dm ? bus.dm_addr : bus.if_addr;
      m_we     = m_own_dm && bus.dm_we;
      m_wdata  = bus.dm_wdata;
    end
  endtask

  task automatic cycle_step(input bit r);
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    if (auto_mode != 0) begin
      if (!pend[0] && (auto_mode == 2 || $urandom_range(0, 2) == 0))
        start_txn(0, {26'h0, 4'($urandom_range(0, 15)), 2'b00}, 1'b0, 32'h0);
      if (!pend[1] && (auto_mode == 2 || $urandom_range(0, 2) == 0))
        start_txn(1, {26'h0, 4'($urandom_range(0, 15)), 2'b00}, 1'($urandom_range(0, 1)), $urandom());
    end
    for (int p = 0; p < 2; p++)
      if (auto_mode == 1 && inflight(p) && !dropped[p] && $urandom_range(0, 5) == 0) dropped[p] = 1'b1;
    bus.if_req   = pend[0] && !dropped[0];
    bus.dm_req   = pend[1] && !dropped[1];
    bus.if_addr  = inflight(0) ? $urandom() : t_addr[0];
    bus.dm_addr  = inflight(1) ? $urandom() : t_addr[1];
    bus.dm_we    = inflight(1) ? 1'($urandom_range(0, 1)) : t_we;
    bus.dm_wdata = inflight(1) ? $urandom() : t_wdata;
    bus.mem_rdata = (cyc == env_issue_c + LAT) ? env_rd(bus.mem_addr) : $urandom();
    model_eval();
    @(negedge clk);
    chk("if_gnt", bus.if_gnt, x_if_gnt);
    chk("dm_gnt", bus.dm_gnt, x_dm_gnt);
    chk("if_rvalid", bus.if_rvalid, x_if_rv);
    chk("dm_rvalid", bus.dm_rvalid, x_dm_rv);
    chk("if_rdata", bus.if_rdata, e_if_rdata);
    chk("dm_rdata", bus.dm_rdata, e_dm_rdata);
    chk("mem_en", bus.mem_en, x_mem_en);
    chk("mem_we", bus.mem_we, x_mem_we);
    chk("mem_addr", bus.mem_addr, e_mem_addr);
    if (x_mem_we || rst) chk("mem_wdata", bus.mem_wdata, e_mem_wdata);
    chk("busy", bus.busy, x_busy);
    chk("stall_if", bus.stall_if, x_stall_if);
    chk("stall_mem", bus.stall_mem, x_stall_mem);
    if (!rst && bus.mem_en) begin
      env_issue_c = cyc;
      if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
    end
    if (x_if_rv) begin pend[0] = 1'b0; dropped[0] = 1'b0; end
    if (x_dm_rv) begin pend[1] = 1'b0; dropped[1] = 1'b0; end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; auto_mode = 0;
    rst = 1'b1;
    pend[0] = 0; pend[1] = 0; dropped[0] = 0; dropped[1] = 0;
    t_addr[0] = '0; t_addr[1] = '0; t_we = 0; t_wdata = '0;
    m_active = 0; m_own_dm = 0; m_gnt_c = -100; m_done_c = -100;
    m_addr = '0; m_we = 0; m_wdata = '0;
    e_if_rdata = '0; e_dm_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0;
    env_issue_c = -100;
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = '0;
    repeat (2) cycle_step(1'b1);

    // single fetch from 0x40
    env_mem[32'h40] = 32'h8C010004;
    ref_mem[32'h40] = 32'h8C010004;
    start_txn(0, 32'h40, 1'b0, 32'h0);
    repeat (6) cycle_step(1'b0);

    // simultaneous fetch and data read
    start_txn(1, 32'h100, 1'b0, 32'h0);
    start_txn(0, 32'h44, 1'b0, 32'h0);
    repeat (10) cycle_step(1'b0);

    // write then read back
    start_txn(1, 32'h200, 1'b1, 32'hDEADBEEF);
    repeat (6) cycle_step(1'b0);
    start_txn(1, 32'h200, 1'b0, 32'h0);
    repeat (6) cycle_step(1'b0);

    // continuous load from both sides
    auto_mode = 2;
    repeat (40) cycle_step(1'b0);
    auto_mode = 0;
    repeat (10) cycle_step(1'b0);

    // reset two cycles after the data grant, request still held
    start_txn(1, 32'h300, 1'b0, 32'h0);
    repeat (3) cycle_step(1'b0);
    repeat (2) cycle_step(1'b1);
    repeat (8) cycle_step(1'b0);

    // random traffic with drops, address churn and occasional resets
    auto_mode = 1;
    repeat (600) cycle_step($urandom_range(0, 99) == 0);
    auto_mode = 0;
    repeat (12) cycle_step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
